exu_mdu: RTL and testbench
==========================

Name: exu_mdu

Overview:
- Parametrised multi-cycle M-extension execute unit. Sits in the EX stage beside the single-cycle ALU and takes the MUL/DIV/REM class ops (including W forms).
- Uses valid/ready handshakes on both sides so the pipeline can stall while an iterative multiply or divide runs.
- Carries a destination tag alongside each op, so write-back needs no side state.
- Flush input kills an in-flight op on redirect or trap.

Parameters:
- XLEN, 64, datapath width; must be even and ≥ 8.
- TAG_W, 5, width of opaque destination tag (rd address).
- MUL_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide XLEN/2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- i_flush  in  1  abort current op; highest priority.
- i_valid  in  1  op present.
- o_ready  out  1  unit can accept; high only in IDLE.
- i_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_word_op  in  1  W form: operate on low XLEN/2 bits, sign-extend result. funct3 1–3 with i_word_op=1 is illegal; it is treated as MUL-W.
- i_src1  in  XLEN  rs1 value.
- i_src2  in  XLEN  rs2 value.
- i_tag  in  TAG_W  destination tag.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  result.
- o_tag  out  TAG_W  tag captured at accept.
- o_busy  out  1  state ≠ IDLE (for hazard logic).

Behaviour:
- Reset (async assert, sync release): state IDLE. o_valid=0, o_ready=1, o_busy=0, o_result=0, o_tag=0, all counters and accumulators 0.
- States: IDLE, CALC, DONE.
  - IDLE→CALC on i_valid & o_ready; operands, funct3, word_op and tag are latched that edge.
  - IDLE→DONE directly on a special-case divide (see below).
  - CALC→DONE when the iteration counter reaches its terminal count.
  - DONE→IDLE on o_valid & i_ready.
  - i_flush in any state → IDLE next edge; no o_valid is produced for the killed op. i_flush in the same cycle as i_valid: the op is not accepted.
- Effective width W = XLEN, or XLEN/2 when word_op.
- Operand prep:
  - W forms use low W bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed ops take magnitudes and record the result sign.
  - MULHSU: only src1 is treated as signed.
- Multiply: shift-add, MUL_BITS per cycle, 2W-bit product.
  - CALC lasts W/MUL_BITS cycles.
  - MUL returns the low W bits; MULH/MULHSU/MULHU return the high W bits.
  - Negation is applied to the full 2W-bit product before selection.
- Divide: restoring radix-2, 1 bit per cycle; CALC lasts W cycles.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign of dividend.
- Special cases, resolved at accept with no CALC (o_valid rises the cycle after accept):
  - Divisor zero: quotient = all ones (−1); remainder = dividend (W bits).
  - Signed overflow (dividend = −2^(W−1), divisor = −1): quotient = dividend; remainder = 0.
- W-form result: the low W bits are sign-extended to XLEN (this applies to DIVUW/REMUW as well).
- Latency, accept edge to first o_valid high cycle:
  - Normal ops: CALC cycles + 1.
  - Special divides: 1.
- Output rules:
  - o_result and o_tag are stable while o_valid=1 and i_ready=0.
  - o_valid deasserts the cycle after the handshake.
  - There is no back-to-back accept: o_ready rises the cycle after DONE exits.
- Async reset mid-CALC: outputs return to reset values immediately.

Test Plan:
- XLEN=64: MUL 7×−3 → o_result=0xFFFFFFFFFFFFFFEB. o_valid asserts 65 cycles after accept; tag 5'd9 echoed.
- MULH src1=src2=0x8000000000000000 → 0x4000000000000000. MULHU 0xFFFFFFFFFFFFFFFF×2 → 1. MULHSU −1×2 → 0xFFFFFFFFFFFFFFFF.
- DIV −7/2 → −3; REM −7/2 → −1. DIVUW 0x00000000FFFFFFFE/2 → 0x000000007FFFFFFF, with latency 33.
- DIV x/0 → all ones; REMU 0x1234/0 → 0x1234. DIV 0x8000000000000000/−1 → 0x8000000000000000, REM → 0. Each has o_valid one cycle after accept.
- Backpressure: i_ready held low 10 cycles in DONE → o_result/o_tag stable, o_ready=0. Release → o_valid drops next cycle and o_ready rises.
- Flush at CALC cycle 20, then a new MUL 3×4 → only 12 emerges. Async rst asserted mid-CALC → o_valid=0 and o_ready=1 immediately.

Source files
------------

// File: rtl/exu_mdu.sv
// exu_mdu: multi-cycle M-extension execute unit (MUL/MULH*/DIV*/REM*, incl. W forms).
// Shift-add multiply retiring MUL_BITS bits per cycle, restoring radix-2 divide,
// divide-by-zero and signed overflow resolved at accept without iterating.
module exu_mdu #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic             i_word_op,
  input  logic [XLEN-1:0]  i_src1,
  input  logic [XLEN-1:0]  i_src2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int unsigned H  = XLEN / 2;
  localparam int unsigned CW = $clog2(XLEN) + 1;

  localparam logic [CW-1:0]   LAST_MUL_D = CW'(XLEN / MUL_BITS - 1);
  localparam logic [CW-1:0]   LAST_MUL_W = CW'(H / MUL_BITS - 1);
  localparam logic [CW-1:0]   LAST_DIV_D = CW'(XLEN - 1);
  localparam logic [CW-1:0]   LAST_DIV_W = CW'(H - 1);
  localparam logic [XLEN-1:0] MIN_D      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W      = {{(H+1){1'b1}}, {(H-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  logic [2:0]        f3_q;
  logic              word_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_last;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   dvsr;

  function automatic logic [XLEN-1:0] wsext(input logic [XLEN-1:0] v, input logic w);
    return w ? {{H{v[H-1]}}, v[H-1:0]} : v;
  endfunction

  logic              accept;
  logic              is_div;
  logic              sgn1;
  logic              sgn2;
  logic              neg1;
  logic              neg2;
  logic              neg_res;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [2:0]        f3;
  logic [XLEN-1:0]   a_ext;
  logic [XLEN-1:0]   b_ext;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [XLEN-1:0]   spec_val;
  logic [CW-1:0]     last_n;

  // Accept-side decode: operand extension, magnitudes, result sign, special divides.
  always_comb begin
    f3       = (i_word_op && (i_funct3 inside {3'd1, 3'd2, 3'd3})) ? 3'd0 : i_funct3;
    is_div   = f3[2];
    sgn1     = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    sgn2     = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    a_ext    = i_src1;
    b_ext    = i_src2;
    if (i_word_op) begin
      a_ext = sgn1 ? wsext(i_src1, 1'b1) : {{H{1'b0}}, i_src1[H-1:0]};
      b_ext = sgn2 ? wsext(i_src2, 1'b1) : {{H{1'b0}}, i_src2[H-1:0]};
    end
    neg1     = sgn1 & a_ext[XLEN-1];
    neg2     = sgn2 & b_ext[XLEN-1];
    mag1     = neg1 ? -a_ext : a_ext;
    mag2     = neg2 ? -b_ext : b_ext;
    // remainder follows the dividend; product and quotient follow sign1 ^ sign2
    neg_res  = (is_div && f3[1]) ? neg1 : (neg1 ^ neg2);
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && sgn2 && (a_ext == (i_word_op ? MIN_W : MIN_D)) && (b_ext == '1);
    special  = div_zero || div_ovf;
    spec_val = '0;
    if (div_zero) begin
      spec_val = f3[1] ? a_ext : '1;
    end else if (div_ovf) begin
      spec_val = f3[1] ? '0 : a_ext;
    end
    spec_val = wsext(spec_val, i_word_op);
    if (is_div) begin
      last_n = i_word_op ? LAST_DIV_W : LAST_DIV_D;
    end else begin
      last_n = i_word_op ? LAST_MUL_W : LAST_MUL_D;
    end
    accept   = i_valid && (state == IDLE) && !i_flush;
  end

  logic [2*XLEN-1:0] acc_n;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     shl;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   rem_n;
  logic [XLEN-1:0]   quot_n;
  logic [XLEN-1:0]   mul_sel;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fin;

  // One iteration step of both engines plus the final sign/select/extend of the result.
  always_comb begin
    acc_n = acc;
    for (int unsigned b = 0; b < MUL_BITS; b++) begin
      if (mplier[b]) acc_n = acc_n + (mcand << b);
    end
    shl     = {rem, quot[XLEN-1]};
    trial   = shl - {1'b0, dvsr};
    rem_n   = trial[XLEN] ? shl[XLEN-1:0] : trial[XLEN-1:0];
    quot_n  = {quot[XLEN-2:0], !trial[XLEN]};
    prod    = neg_q ? -acc_n : acc_n;
    mul_sel = (f3_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_sel = f3_q[1] ? rem_n : quot_n;
    if (neg_q) div_sel = -div_sel;
    fin     = wsext(f3_q[2] ? div_sel : mul_sel, word_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_n = state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b1;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (accept) state_n = special ? DONE : CALC;
      end
      CALC: begin
        if (cnt == cnt_last) state_n = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (i_flush) state_n = IDLE;
  end

  // Operand latch at accept, iteration in CALC, result capture on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      cnt_last <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      o_result <= '0;
      o_tag    <= '0;
    end else if (accept) begin
      f3_q     <= f3;
      word_q   <= i_word_op;
      neg_q    <= neg_res;
      cnt      <= '0;
      cnt_last <= last_n;
      acc      <= '0;
      mcand    <= {{XLEN{1'b0}}, mag1};
      mplier   <= mag2;
      rem      <= '0;
      // dividend is left-aligned so the divider always consumes from the top bit
      quot     <= i_word_op ? {mag1[H-1:0], {H{1'b0}}} : mag1;
      dvsr     <= mag2;
      o_tag    <= i_tag;
      if (special) o_result <= spec_val;
    end else if (state == CALC && !i_flush) begin
      acc    <= acc_n;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
      rem    <= rem_n;
      quot   <= quot_n;
      cnt    <= cnt + 1'b1;
      if (cnt == cnt_last) o_result <= fin;
    end
  end

endmodule

// File: tb/tb_exu_mdu.sv
// tb_exu_mdu: directed vectors with literal expectations, plus a native-arithmetic
// reference model and a scoreboard compare process checking every valid result.
module tb_exu_mdu;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned MUL_BITS = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_funct3;
  logic              i_word_op;
  logic [XLEN-1:0]   i_src1;
  logic [XLEN-1:0]   i_src2;
  logic [TAG_W-1:0]  i_tag;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_result;
  logic [TAG_W-1:0]  o_tag;
  logic              o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_res_q[$];
  logic [4:0]  exp_tag_q[$];

  always #5 clk = ~clk;

  exu_mdu #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_BITS(MUL_BITS)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_word_op(i_word_op), .i_src1(i_src1), .i_src2(i_src2),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_tag(o_tag), .o_busy(o_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference result straight from the RISC-V M-extension definitions.
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [2:0]          op;
    logic [31:0]         r32;
    int                  sa32;
    int                  sb32;
    longint              sa;
    longint              sb;
    logic [127:0]        p;
    logic signed [127:0] x;
    logic signed [127:0] y;
    logic                ovf;
    op = (w && (f3 inside {3'd1, 3'd2, 3'd3})) ? 3'd0 : f3;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      ovf  = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
      r32  = '0;
      case (op)
        3'd4: if (b[31:0] == 0) r32 = '1; else if (ovf) r32 = a[31:0]; else r32 = sa32 / sb32;
        3'd5: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'd6: if (b[31:0] == 0) r32 = a[31:0]; else if (ovf) r32 = '0; else r32 = sa32 % sb32;
        3'd7: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa  = a;
    sb  = b;
    ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
    case (op)
      3'd1: begin x = $signed(a); y = $signed(b); p = x * y; return p[127:64]; end
      3'd2: begin x = $signed(a); y = {64'b0, b}; p = x * y; return p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      3'd4: if (b == 0) return '1; else if (ovf) return a; else return sa / sb;
      3'd5: if (b == 0) return '1; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return '0; else return sa % sb;
      3'd7: if (b == 0) return a; else return a % b;
      default: return a * b;
    endcase
  endfunction

  // Scoreboard: every cycle with a valid result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_ready", o_busy, !o_ready);
      if (o_valid) begin
        if (exp_res_q.size() == 0) begin
          chk("unexpected_valid", o_valid, 0);
        end else begin
          chk("model_result", o_result, exp_res_q[0]);
          chk("model_tag", o_tag, exp_tag_q[0]);
          if (i_ready) begin
            void'(exp_res_q.pop_front());
            void'(exp_tag_q.pop_front());
          end
        end
      end
    end
  end

  // Issue one op from an idle unit, check latency, literal result, tag and backpressure.
  task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] lit, input int hold);
    logic [2:0]  op;
    logic        sp;
    int          lat;
    int          k;
    op  = (w && (f3 inside {3'd1, 3'd2, 3'd3})) ? 3'd0 : f3;
    sp  = op[2] && ((w ? (b[31:0] == 0) : (b == 0)) ||
          (!op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1))));
    lat = sp ? 1 : ((op[2] ? (w ? 32 : 64) : (w ? 32 : 64) / MUL_BITS) + 1);
    chk({name, " ready_before"}, o_ready, 1);
    exp_res_q.push_back(model(f3, w, a, b));
    exp_tag_q.push_back(tag);
    i_valid = 1'b1; i_funct3 = f3; i_word_op = w; i_src1 = a; i_src2 = b; i_tag = tag;
    @(posedge clk); #1;
    i_valid = 1'b0;
    k = 0;
    while (!o_valid && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, " latency"}, 64'(k + 1), 64'(lat));
    chk({name, " result"}, o_result, lit);
    chk({name, " tag"}, o_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, " hold_valid"}, o_valid, 1);
      chk({name, " hold_ready"}, o_ready, 0);
      chk({name, " hold_result"}, o_result, lit);
      chk({name, " hold_tag"}, o_tag, tag);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk({name, " valid_drop"}, o_valid, 0);
    chk({name, " ready_rise"}, o_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_funct3 = '0; i_word_op = 1'b0;
    i_src1 = '0; i_src2 = '0; i_tag = '0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_valid", o_valid, 0);
    chk("reset o_ready", o_ready, 1);
    chk("reset o_busy", o_busy, 0);
    chk("reset o_result", o_result, 0);
    chk("reset o_tag", o_tag, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_op("MUL 7*-3",      3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("MULH min*min",  3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd1, 64'h4000_0000_0000_0000, 0);
    run_op("MULHU max*2",   3'd3, 1'b0, '1, 64'd2, 5'd2, 64'd1, 0);
    run_op("MULHSU -1*2",   3'd2, 1'b0, '1, 64'd2, 5'd3, '1, 0);
    run_op("DIV -7/2",      3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("REM -7/2",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, '1, 0);
    run_op("DIVUW",         3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 5'd6, 64'h0000_0000_7FFF_FFFF, 0);
    run_op("DIV x/0",       3'd4, 1'b0, 64'd5, 64'd0, 5'd7, '1, 0);
    run_op("REMU x/0",      3'd7, 1'b0, 64'h1234, 64'd0, 5'd8, 64'h1234, 0);
    run_op("DIV ovf",       3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd10, 64'h8000_0000_0000_0000, 0);
    run_op("REM ovf",       3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 64'd0, 0);
    run_op("MULW",          3'd0, 1'b1, 64'hAAAA_0000_7FFF_FFFF, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("DIVW -7/2",     3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("REMUW x/0",     3'd7, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 5'd14, '1, 0);
    run_op("DIVW ovf",      3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd15, 64'hFFFF_FFFF_8000_0000, 0);
    run_op("MULHW as MULW", 3'd1, 1'b1, 64'd3, 64'd5, 5'd16, 64'd15, 0);
    run_op("DIVU big",      3'd5, 1'b0, 64'd1000001, 64'd7, 5'd17, 64'd142857, 0);
    run_op("REMU backpr",   3'd7, 1'b0, 64'd1000001, 64'd7, 5'd18, 64'd2, 10);

    // flush mid-CALC: killed op must never appear on the output
    i_valid = 1'b1; i_funct3 = 3'd0; i_word_op = 1'b0; i_src1 = 64'h55; i_src2 = 64'h77; i_tag = 5'd30;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("flush pre_busy", o_busy, 1);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush busy", o_busy, 0);
    chk("flush ready", o_ready, 1);
    // flush together with valid: op not taken
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_valid busy", o_busy, 0);
    run_op("MUL 3*4 after flush", 3'd0, 1'b0, 64'd3, 64'd4, 5'd19, 64'd12, 0);

    // asynchronous reset in the middle of CALC
    i_valid = 1'b1; i_funct3 = 3'd4; i_word_op = 1'b0; i_src1 = 64'd99; i_src2 = 64'd5; i_tag = 5'd21;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst o_valid", o_valid, 0);
    chk("arst o_ready", o_ready, 1);
    chk("arst o_busy", o_busy, 0);
    chk("arst o_result", o_result, 0);
    chk("arst o_tag", o_tag, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_op("MULHU after rst", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd22, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    chk("scoreboard drained", 64'(exp_res_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
